// File: rtl/zone_irrigation_controller_pkg.sv
// irrigation_pkg: shared FSM state type and sizing/validity helpers for the irrigation controller.
package irrigation_pkg;
    typedef enum logic [1:0] {SCAN, IRRIGATE, SOAK, FAULT} state_t;

    function automatic logic therm_valid(input logic [7:0] v);
        return &(~v[7:1] | v[6:0]);
    endfunction

    function automatic int zone_w(input int zones);
        return zones > 1 ? $clog2(zones) : 1;
    endfunction

    function automatic int cnt_w(input int run_ticks, input int soak_ticks);
        return $clog2((run_ticks > soak_ticks ? run_ticks : soak_ticks) + 1);
    endfunction
endpackage

// File: rtl/zone_irrigation_controller_if.sv
// zone_irrigation_controller_if: sensor inputs and actuator/status outputs of the irrigation controller.
interface zone_irrigation_controller_if import irrigation_pkg::*; #(
    parameter int ZONES = 4,
    parameter int LEVELS = 3,
    parameter int RUN_TICKS = 180,
    parameter int SOAK_TICKS = 30
);
    localparam int ZW = zone_w(ZONES);
    localparam int CW = cnt_w(RUN_TICKS, SOAK_TICKS);
    logic tick;
    logic [LEVELS-1:0] water_levels;
    logic [ZONES-1:0] earth_humidity;
    logic air_humidity;
    logic low_temperature;
    logic splinker_bomb;
    logic [ZONES-1:0] dripper_valvules;
    logic water_supply_valvule;
    logic alarm;
    logic conflicting_values;
    logic [ZW-1:0] active_zone;
    logic [CW-1:0] remaining_ticks;

    modport master (
        output tick, water_levels, earth_humidity, air_humidity, low_temperature,
        input splinker_bomb, dripper_valvules, water_supply_valvule, alarm,
        input conflicting_values, active_zone, remaining_ticks
    );

    modport slave (
        input tick, water_levels, earth_humidity, air_humidity, low_temperature,
        output splinker_bomb, dripper_valvules, water_supply_valvule, alarm,
        output conflicting_values, active_zone, remaining_ticks
    );
endinterface

// File: rtl/zone_irrigation_controller_validator.sv
// water_level_validator: flags whether the level sensor vector is thermometer-coded.
module water_level_validator import irrigation_pkg::*; #(
    parameter int LEVELS = 3
) (
    input logic [LEVELS-1:0] levels,
    output logic valid
);
    assign valid = therm_valid(8'(levels));
endmodule

// File: rtl/zone_irrigation_controller.sv
// zone_irrigation_controller: zone-scanning irrigation FSM with refill hysteresis and fault lockout; IRRIG_SOAK_EN adds a post-burst SOAK pause.
module zone_irrigation_controller import irrigation_pkg::*; #(
    parameter int ZONES = 4,
    parameter int LEVELS = 3,
    parameter int MID_LEVEL = 1,
    parameter int RUN_TICKS = 180,
    parameter int SOAK_TICKS = 30
) (
    input logic clock,
    input logic reset_n,
    zone_irrigation_controller_if.slave bus
);
    localparam int ZW = zone_w(ZONES);
    localparam int CW = cnt_w(RUN_TICKS, SOAK_TICKS);

    state_t state, state_nxt;
    logic [ZW-1:0] zone, zone_nxt, zone_inc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [ZONES-1:0] drip, drip_nxt;
    logic [LEVELS-1:0] lv;
    logic mode, mode_nxt, fcnt, fcnt_nxt, valid, burst_end, rest_end;
    logic spr, spr_nxt, wsv, wsv_nxt, alarm, alarm_nxt, conf, conf_nxt;

    assign lv = bus.water_levels;

    water_level_validator #(.LEVELS(LEVELS)) u_validator (
        .levels(lv),
        .valid(valid)
    );

    assign zone_inc = zone == ZW'(ZONES - 1) ? '0 : zone + ZW'(1);
    assign rest_end = bus.tick && cnt == CW'(1);
    // early stop and the final tick end the burst identically, so no priority logic is needed
    assign burst_end = bus.earth_humidity[zone] || !lv[0] || rest_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN;
            zone <= '0;
            cnt <= '0;
            mode <= 1'b0;
            fcnt <= 1'b0;
            spr <= 1'b0;
            drip <= '0;
            wsv <= 1'b0;
            alarm <= 1'b0;
            conf <= 1'b0;
        end else begin
            state <= state_nxt;
            zone <= zone_nxt;
            cnt <= cnt_nxt;
            mode <= mode_nxt;
            fcnt <= fcnt_nxt;
            spr <= spr_nxt;
            drip <= drip_nxt;
            wsv <= wsv_nxt;
            alarm <= alarm_nxt;
            conf <= conf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN: if (!bus.earth_humidity[zone] && lv[0]) state_nxt = IRRIGATE;
`ifdef IRRIG_SOAK_EN
            IRRIGATE: if (burst_end) state_nxt = SOAK;
            SOAK: if (rest_end) state_nxt = SCAN;
`else
            IRRIGATE: if (burst_end) state_nxt = SCAN;
`endif
            FAULT: if (bus.tick && fcnt) state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
        if (!valid) state_nxt = FAULT;
    end

    // outputs are registered images of the next state, so they line up with the state register
    always_comb begin
        zone_nxt = (state_nxt == FAULT || state == FAULT) ? '0 : state_nxt == SCAN ? zone_inc : zone;
        cnt_nxt = state_nxt == IRRIGATE ? (state == IRRIGATE ? cnt - CW'(bus.tick) : CW'(RUN_TICKS))
                : state_nxt == SOAK ? (state == SOAK ? cnt - CW'(bus.tick) : CW'(SOAK_TICKS)) : '0;
        mode_nxt = state == IRRIGATE ? mode : !bus.air_humidity && !bus.low_temperature && lv[MID_LEVEL];
        fcnt_nxt = (state == FAULT && state_nxt == FAULT && valid) ? (fcnt | bus.tick) : 1'b0;
        spr_nxt = state_nxt == IRRIGATE && mode_nxt;
        drip_nxt = (state_nxt == IRRIGATE && !mode_nxt) ? ZONES'(1) << zone_nxt : '0;
        wsv_nxt = (state_nxt == FAULT || lv[LEVELS-1]) ? 1'b0 : !lv[MID_LEVEL] ? 1'b1 : wsv;
        alarm_nxt = state_nxt == FAULT || !lv[MID_LEVEL];
        conf_nxt = state_nxt == FAULT;
    end

    assign bus.splinker_bomb = spr;
    assign bus.dripper_valvules = drip;
    assign bus.water_supply_valvule = wsv;
    assign bus.alarm = alarm;
    assign bus.conflicting_values = conf;
    assign bus.active_zone = zone;
    assign bus.remaining_ticks = cnt;
endmodule
